// File: rtl/rotary_quadrature_gen_pkg.sv
// Shared definitions for the rotary quadrature generator: FSM states,
// 2-bit quadrature phase codes, direction constants and phase lookup helpers.
package rotary_quadrature_gen_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PHASE,
    S_DONE
  } state_t;

  localparam logic [1:0] Q_00 = 2'b00;
  localparam logic [1:0] Q_01 = 2'b01;
  localparam logic [1:0] Q_11 = 2'b11;
  localparam logic [1:0] Q_10 = 2'b10;

  localparam logic DIR_L = 1'b0;
  localparam logic DIR_R = 1'b1;

  // {A,B} code for phase index idx; index 3 is always the 00 rest code.
  // Right: 01,11,10,00   Left: 10,11,01,00
  function automatic logic [1:0] phase_code(input logic dir, input logic [1:0] idx);
    case (idx)
      2'd0:    return (dir == DIR_R) ? Q_01 : Q_10;
      2'd1:    return Q_11;
      2'd2:    return (dir == DIR_R) ? Q_10 : Q_01;
      default: return Q_00;
    endcase
  endfunction

  // True for the phase in which channel A rises.
  function automatic logic a_rises(input logic dir, input logic [1:0] idx);
    return (dir == DIR_R) ? (idx == 2'd1) : (idx == 2'd0);
  endfunction

endpackage

// File: rtl/rotary_quadrature_gen_phase_timer.sv
// Free-running phase timer: counts 0..PHASE_CYCLES-1 and flags the terminal
// count. Every terminal count is an advance, so the count wraps to 0 there.
module phase_timer #(
  parameter int unsigned PHASE_CYCLES = 50000,
  parameter int unsigned TIMER_W      = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(PHASE_CYCLES - 1);

  logic [TIMER_W-1:0] cnt;

  // Phase cycle counter, held at zero while cleared.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + TIMER_W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/rotary_quadrature_gen.sv
// Rotary-encoder quadrature waveform generator: emits cmd_steps detents of
// A/B quadrature in the commanded direction, optionally with a one-cycle
// contact-bounce glitch on every A rise.
module rotary_quadrature_gen
  import rotary_quadrature_gen_pkg::*;
#(
  parameter int unsigned PHASE_CYCLES = 50000,
  parameter int unsigned COUNT_W      = 8,
  parameter int unsigned TIMER_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_dir,
  input  logic [COUNT_W-1:0] cmd_steps,
  input  logic               bounce_en,
  output logic               rot_a,
  output logic               rot_b,
  output logic               busy,
  output logic               done
);

  state_t             state, state_next;
  logic               dir_q;
  logic               bounce_q;
  logic [COUNT_W-1:0] steps_q;
  logic [1:0]         idx_q;
  logic [1:0]         bnc_cnt;
  logic               tick;
  logic               accept;
  logic               last_detent;
  logic               end_of_detent;

  assign cmd_ready     = (state == S_IDLE) || (state == S_DONE);
  assign busy          = (state == S_PHASE);
  assign done          = (state == S_DONE);
  assign accept        = cmd_valid && cmd_ready;
  assign last_detent   = (steps_q == COUNT_W'(1));
  assign end_of_detent = tick && (idx_q == 2'd3);

  phase_timer #(
    .PHASE_CYCLES (PHASE_CYCLES),
    .TIMER_W      (TIMER_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (state != S_PHASE),
    .tick  (tick)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; DONE accepts a new command just like IDLE.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_next = (cmd_steps == '0) ? S_DONE : S_PHASE;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_PHASE: begin
        if (end_of_detent && last_detent) begin
          state_next = S_DONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Command latch, step counter, phase index, bounce sub-counter and outputs.
  // The step count is decremented at the end of each rest phase rather than on
  // entry to it; the final rest phase is recognised by a count of one.
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q    <= DIR_L;
      bounce_q <= 1'b0;
      steps_q  <= '0;
      idx_q    <= 2'd0;
      bnc_cnt  <= 2'd0;
      rot_a    <= 1'b0;
      rot_b    <= 1'b0;
    end else if (accept) begin
      dir_q    <= cmd_dir;
      bounce_q <= bounce_en;
      steps_q  <= cmd_steps;
      idx_q    <= 2'd0;
      bnc_cnt  <= 2'd0;
      if (cmd_steps != '0) begin
        {rot_a, rot_b} <= phase_code(cmd_dir, 2'd0);
      end
    end else if (state == S_PHASE) begin
      if (tick) begin
        idx_q   <= idx_q + 2'd1;
        bnc_cnt <= 2'd0;
        if (!(end_of_detent && last_detent)) begin
          {rot_a, rot_b} <= phase_code(dir_q, idx_q + 2'd1);
        end
        if (end_of_detent && !last_detent) begin
          steps_q <= steps_q - COUNT_W'(1);
        end
      end else if (bounce_q && a_rises(dir_q, idx_q) && (bnc_cnt != 2'd2)) begin
        // Glitch: new A (1 cycle), old A (1 cycle), then new A to phase end.
        bnc_cnt <= bnc_cnt + 2'd1;
        rot_a   <= (bnc_cnt == 2'd1);
      end
    end
  end

endmodule

// File: tb/tb_rotary_quadrature_gen.sv
// Self-checking bench for rotary_quadrature_gen with PHASE_CYCLES=4.
// Expected per-cycle {A,B,busy,done,ready} vectors are queued when a command
// is issued and compared cycle by cycle; a small debouncing decoder model
// counts right/left detents from rot_a/rot_b.
module tb_rotary_quadrature_gen;

  localparam int unsigned PC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_dir;
  logic [7:0] cmd_steps;
  logic       bounce_en;
  logic       rot_a;
  logic       rot_b;
  logic       busy;
  logic       done;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [4:0] exp_q[$];

  rotary_quadrature_gen #(
    .PHASE_CYCLES (PC),
    .COUNT_W      (8),
    .TIMER_W      (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_steps (cmd_steps),
    .bounce_en (bounce_en),
    .rot_a     (rot_a),
    .rot_b     (rot_b),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Decoder model: A must be stable for two samples to count as an edge;
  // B high at a valid A rise means right, low means left.
  logic        a_s1 = 1'b0;
  logic        a_db = 1'b0;
  int unsigned r_cnt = 0;
  int unsigned l_cnt = 0;

  always @(posedge clk) begin
    a_s1 <= rot_a;
    if (rot_a === a_s1 && rot_a !== a_db) begin
      a_db <= rot_a;
      if (rot_a) begin
        if (rot_b) r_cnt <= r_cnt + 1;
        else       l_cnt <= l_cnt + 1;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] code_of(input logic dir, input int k);
    logic [1:0] c;
    case (k)
      0:       c = dir ? 2'b01 : 2'b10;
      1:       c = 2'b11;
      2:       c = dir ? 2'b10 : 2'b01;
      default: c = 2'b00;
    endcase
    return c;
  endfunction

  function automatic logic [4:0] ent(input logic [1:0] ab, input logic bsy,
                                     input logic dn, input logic rdy);
    return {ab, bsy, dn, rdy};
  endfunction

  function automatic logic [4:0] observed();
    return {rot_a, rot_b, busy, done, cmd_ready};
  endfunction

  // Queue the cycle-by-cycle expectation for one command starting after accept.
  task automatic push_cmd(input logic dir, input int steps, input logic bnc);
    logic [1:0] ab;
    logic       rise;
    for (int d = 0; d < steps; d++) begin
      for (int k = 0; k < 4; k++) begin
        rise = dir ? (k == 1) : (k == 0);
        for (int c = 0; c < int'(PC); c++) begin
          ab = code_of(dir, k);
          if (bnc && rise && c == 1) ab[1] = 1'b0;
          exp_q.push_back(ent(ab, 1'b1, 1'b0, 1'b0));
        end
      end
    end
    exp_q.push_back(ent(2'b00, 1'b0, 1'b1, 1'b1));
  endtask

  // Offer a command; returns just after the accepting edge.
  task automatic issue(input logic dir, input int steps, input logic bnc, input bit keep);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_steps = steps[7:0];
    bounce_en = bnc;
    push_cmd(dir, steps, bnc);
    @(posedge clk); #1;
    if (!keep) cmd_valid = 1'b0;
  endtask

  // Compare queued expectations each cycle; optionally drop cmd_valid after
  // the edge that follows entry number drop_after.
  task automatic drain(input string tag, input int max_n, input int drop_after);
    logic [4:0] e;
    int         n;
    n = 0;
    while (exp_q.size() != 0 && n < max_n) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n++;
      check_val(tag, 32'(observed()), 32'(e));
      if (n == drop_after) begin
        @(posedge clk); #1;
        cmd_valid = 1'b0;
      end
    end
  endtask

  int unsigned r0, l0;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_dir   = 1'b0;
    cmd_steps = 8'd0;
    bounce_en = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("reset", 32'(observed()), 32'(ent(2'b00, 1'b0, 1'b0, 1'b1)));

    // Right x3
    r0 = r_cnt; l0 = l_cnt;
    issue(1'b1, 3, 1'b0, 1'b0);
    drain("right3", 1000, 0);
    repeat (2) @(posedge clk);
    check_val("right3_rcnt", r_cnt - r0, 3);
    check_val("right3_lcnt", l_cnt - l0, 0);

    // Left x1 with bounce
    r0 = r_cnt; l0 = l_cnt;
    issue(1'b0, 1, 1'b1, 1'b0);
    drain("left1_bounce", 1000, 0);
    repeat (2) @(posedge clk);
    check_val("left1_lcnt", l_cnt - l0, 1);
    check_val("left1_rcnt", r_cnt - r0, 0);

    // Zero steps
    r0 = r_cnt; l0 = l_cnt;
    issue(1'b1, 0, 1'b0, 1'b0);
    drain("zero_steps", 1000, 0);
    @(negedge clk);
    check_val("zero_idle", 32'(observed()), 32'(ent(2'b00, 1'b0, 1'b0, 1'b1)));
    check_val("zero_cnt", (r_cnt - r0) + (l_cnt - l0), 0);

    // cmd_valid held with other dir while busy; taken on the DONE cycle
    r0 = r_cnt; l0 = l_cnt;
    issue(1'b1, 1, 1'b0, 1'b1);
    cmd_dir   = 1'b0;
    cmd_steps = 8'd1;
    push_cmd(1'b0, 1, 1'b0);
    drain("held_valid", 1000, 4 * PC + 1);
    repeat (2) @(posedge clk);
    check_val("held_rcnt", r_cnt - r0, 1);
    check_val("held_lcnt", l_cnt - l0, 1);

    // Reset in the middle of an AB=11 phase
    issue(1'b1, 2, 1'b0, 1'b0);
    drain("pre_reset", PC + 1, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_val("mid_reset", 32'(observed()), 32'(ent(2'b00, 1'b0, 1'b0, 1'b1)));
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("mid_reset_nodone", 32'(done), 0);
    end
    r0 = r_cnt; l0 = l_cnt;
    issue(1'b1, 1, 1'b0, 1'b0);
    drain("after_reset", 1000, 0);
    repeat (2) @(posedge clk);
    check_val("after_reset_rcnt", r_cnt - r0, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
